// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// start/busy/done handshake; the bcd/ovf outputs only change on the done cycle.
module bin2bcd_seq #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bcd,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(99_999_999);
  localparam logic [4:0]       LAST_CNT = 5'(BIN_W - 1);

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [31:0]      acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [31:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [31:0]      acc_adj;

  // Per-nibble add-3 correction; nibbles are independent, no carry between them.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                             : acc_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = bin;
          acc_d      = 32'd0;
          cnt_d      = 5'd0;
          ovf_flag_d = (bin > MAX_VAL);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {acc_d, sr_d} = {acc_adj[30:0], sr_q, 1'b0};
        cnt_d         = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        // Overflowed inputs still ran the full conversion; only the result is replaced.
        bcd_d   = ovf_flag_q ? 32'h9999_9999 : acc_q;
        ovf_d   = ovf_flag_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= 32'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: conversions, overflow, busy/reset handling and
// back-to-back refresh, each checked against hand-computed BCD values.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One conversion with the start pulse sampled at edge E0; done expected after E28.
  task automatic run_conv(input logic [26:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    int  n;
    bit  seen;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk("latency", 32'(n), 32'd28);
    chk("bcd", bcd, exp_bcd);
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int          dones;
    logic [31:0] last_bcd;
    int          k;
    int          cyc;
    int          last_cyc;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", bcd, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_conv(27'd0,           32'h0000_0000, 1'b0);
    run_conv(27'd12_345_678,  32'h1234_5678, 1'b0);
    run_conv(27'd90_000_001,  32'h9000_0001, 1'b0);
    run_conv(27'd99_999_999,  32'h9999_9999, 1'b0);
    run_conv(27'd100_000_000, 32'h9999_9999, 1'b1);
    run_conv(27'h7FF_FFFF,    32'h9999_9999, 1'b1);

    // Start during a conversion must be ignored, not queued.
    @(negedge clk);
    bin   = 27'd12_345_678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = 27'd5;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    bin      = '0;
    dones    = 0;
    last_bcd = 32'd0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin
        dones++;
        last_bcd = bcd;
      end
    end
    chk("busy_ignore_dones", 32'(dones), 32'd1);
    chk("busy_ignore_bcd", last_bcd, 32'h1234_5678);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bin   = 27'd12_345_678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", bcd, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_conv(27'd42, 32'h0000_0042, 1'b0);

    // Start held high: conversions of 1, 2, 3 back to back.
    @(negedge clk);
    bin      = 27'd1;
    start    = 1'b1;
    k        = 0;
    cyc      = 0;
    last_cyc = 0;
    last_bcd = bcd;
    while (k < 3 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("b2b_bcd", bcd, 32'(k + 1));
        if (k > 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'd29);
        last_cyc = cyc;
        last_bcd = bcd;
        k++;
        if (k == 3) start = 1'b0;
        else        bin   = 27'(k + 1);
      end else begin
        chk("b2b_hold", bcd, last_bcd);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the 8-digit seven-segment scanner. It takes an unsigned binary value and produces eight packed BCD digits, most significant digit in bits [31:28], in the 32-bit nibble format the scanner displays. Conversion uses iterative shift-add-3 (double dabble), one input bit per clock. A start/busy/done handshake lets a counter or measurement block request a refresh. The BCD output holds stable between conversions, so the scanner never shows a partial result.

## Interface
- BIN_W, 27, input width in bits; fixed at 27 because 2^27 covers 99_999_999 (8 digits)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  conversion request; sampled only when busy=0
- bin  in  27  unsigned binary value; captured on the accepting edge
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when bcd/ovf update
- bcd  out  32  eight packed BCD digits; digit 7 is in [31:28], digit 0 is in [3:0]
- ovf  out  1  last captured bin exceeded 99_999_999

## Operation
- States:
  - IDLE → SHIFT when start=1.
  - SHIFT → FINISH after BIN_W shift cycles.
  - FINISH → IDLE unconditionally.
- IDLE, start=1:
  - capture bin into the shift register and clear the 32-bit BCD accumulator;
  - clear the bit counter (5 bits);
  - register the overflow flag: bin > 27'd99_999_999.
- SHIFT, each cycle:
  - every accumulator nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles);
  - then {acc, sr} shifts left by 1, with the sr MSB entering acc[0];
  - the counter increments, and the FSM leaves SHIFT when the counter reaches BIN_W-1.
- FINISH:
  - bcd ← overflow flag ? 32'h9999_9999 : acc;
  - ovf ← overflow flag;
  - done=1 for this cycle only.
- Overflowed inputs still run the full conversion. Only the result is replaced, so latency is data-independent.
- start while busy=1 is ignored, not queued.
- bcd and ovf change only at the FINISH edge and otherwise hold their value indefinitely.
- Input nibbles 0xA–0xF never appear on bcd.

## Timing
- Reset values: busy=0, done=0, bcd=32'h0000_0000, ovf=0; FSM in IDLE; counter, accumulator and shift register all 0.
- Handshake, with start sampled high in IDLE at edge E0:
  - busy=1 from E0;
  - shift cycles run at edges E1..E27;
  - at edge E28, bcd/ovf update, done=1 and busy=0;
  - at edge E29, done=0.
- Latency from start to done is BIN_W+1 = 28 cycles.
- Back-to-back conversions:
  - start=1 during the done cycle is accepted at the next edge, because the FSM is already in IDLE;
  - minimum period is 29 cycles.
- done and busy are never both 1.
- Reset mid-conversion:
  - all outputs return to their reset values immediately (asynchronous);
  - the pending conversion is discarded and bcd is not updated;
  - the first start after rst deasserts behaves normally.
- A start held high continuously restarts a conversion immediately after each done.

## Test plan
- Zero input:
  - after reset, bin=0, start pulse → done at +28 cycles, bcd=32'h0000_0000, ovf=0.
- Mixed digits:
  - bin=12_345_678 → bcd=32'h1234_5678, ovf=0;
  - then bin=90_000_001 → bcd=32'h9000_0001.
- Boundary and overflow:
  - bin=99_999_999 → bcd=32'h9999_9999, ovf=0;
  - bin=100_000_000 → bcd=32'h9999_9999, ovf=1;
  - bin=27'h7FF_FFFF → bcd=32'h9999_9999, ovf=1.
- Busy handling:
  - start pulsed at +5 cycles with a different bin during a conversion → ignored; result matches the first bin; single done.
- Reset mid-conversion:
  - assert rst at +10 cycles of the 12_345_678 conversion → busy=0, bcd=0 at once and no done pulse;
  - new start with bin=42 → bcd=32'h0000_0042.
- Back-to-back:
  - start held high with bin stepping 1, 2, 3 → done pulses spaced 29 cycles apart;
  - bcd=00000001, 00000002, 00000003;
  - bcd holds between pulses.
